// File: rtl/pmp_pkg.sv
// rtl/pmp_pkg.sv - shared widths, frame entry type and thread-mode bound for the PMP bound stack
package pmp_pkg;

    localparam int AddrWidth = 16;
    localparam int PrioWidth = 8;

    typedef struct packed {
        logic [AddrWidth-1:0] ep;
        logic [PrioWidth-1:0] prio;
    } BoundT;

    localparam logic [AddrWidth-1:0] EpThread = '1;

endpackage

// File: rtl/bound_lifo.sv
// rtl/bound_lifo.sv - generic Depth-entry LIFO with push, pop and replace-top, plus level/full/empty
module bound_lifo #(
    parameter int Width = 24,
    parameter int Depth = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   replace,
    input  logic [Width-1:0]       wdata,
    output logic [Width-1:0]       under,
    output logic [$clog2(Depth):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int IW = $clog2(Depth);
    localparam int LW = IW + 1;

    logic [Width-1:0] mem [Depth];
    logic [LW-1:0]    level_q;
    logic [IW-1:0]    push_idx;
    logic [IW-1:0]    top_idx;
    logic [IW-1:0]    under_idx;
    logic             do_push;
    logic             do_pop;
    logic             do_replace;

    // Depth is a power of two, so modulo index arithmetic lands on the right slot
    assign push_idx   = level_q[IW-1:0];
    assign top_idx    = level_q[IW-1:0] - IW'(1);
    assign under_idx  = level_q[IW-1:0] - IW'(2);

    assign full       = (level_q == LW'(Depth));
    assign empty      = (level_q == '0);
    assign level      = level_q;
    assign under      = mem[under_idx];

    assign do_replace = replace && !empty;
    assign do_push    = push && !replace && !full;
    assign do_pop     = pop && !replace && !push && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
        end else if (do_push) begin
            level_q <= level_q + LW'(1);
        end else if (do_pop) begin
            level_q <= level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (do_replace) begin
                mem[top_idx] <= wdata;
            end else if (do_push) begin
                mem[push_idx] <= wdata;
            end
        end
    end

endmodule

// File: rtl/pmp_bound_stack.sv
// rtl/pmp_bound_stack.sv - per-interrupt-level stack-frame upper bound tracker; PMP_BOUND_FAULT_EN adds fault pulse
module pmp_bound_stack
    import pmp_pkg::*;
#(
    parameter int Depth = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enter,
    input  logic [PrioWidth-1:0]   enter_prio,
    input  logic                   exit,
    input  logic [AddrWidth-1:0]   sp,
    output logic [AddrWidth-1:0]   ep,
`ifdef PMP_BOUND_FAULT_EN
    output logic                   fault,
`endif
    output logic [PrioWidth-1:0]   cur_prio,
    output logic [$clog2(Depth):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int LW = $clog2(Depth) + 1;

    BoundT       wr_entry;
    BoundT       under;
    logic        do_push;
    logic        do_pop;
    logic        do_replace;

    assign wr_entry   = '{ep: sp, prio: enter_prio};
    // Tail-chain swaps the top frame; with an empty stack it degrades to a plain entry
    assign do_replace = enter && exit && !empty;
    assign do_push    = enter && (!exit || empty) && !full;
    assign do_pop     = exit && !enter && !empty;

    bound_lifo #(
        .Width ($bits(BoundT)),
        .Depth (Depth)
    ) u_lifo (
        .clk     (clk),
        .reset   (reset),
        .push    (do_push),
        .pop     (do_pop),
        .replace (do_replace),
        .wdata   (wr_entry),
        .under   (under),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ep       <= EpThread;
            cur_prio <= '0;
        end else if (do_push || do_replace) begin
            ep       <= sp;
            cur_prio <= enter_prio;
        end else if (do_pop) begin
            if (level == LW'(1)) begin
                ep       <= EpThread;
                cur_prio <= '0;
            end else begin
                ep       <= under.ep;
                cur_prio <= under.prio;
            end
        end
    end

`ifdef PMP_BOUND_FAULT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fault <= 1'b0;
        end else begin
            fault <= (enter && !exit && full) || (exit && !enter && empty);
        end
    end
`endif

endmodule

// File: tb/tb_pmp_bound_stack.sv
// tb/tb_pmp_bound_stack.sv - directed plus random checks of pmp_bound_stack against a queue reference model
module tb_pmp_bound_stack;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enter = 1'b0;
    logic        exit = 1'b0;
    logic [7:0]  enter_prio = '0;
    logic [15:0] sp = '0;
    logic [15:0] ep;
    logic [7:0]  cur_prio;
    logic [3:0]  level;
    logic        full;
    logic        empty;
`ifdef PMP_BOUND_FAULT_EN
    logic        fault;
`endif

    typedef struct {
        logic [15:0] ep;
        logic [7:0]  prio;
    } frame_t;

    frame_t q[$];
    logic   exp_fault = 1'b0;
    int     errors = 0;
    int     checks = 0;

    always #5 clk = ~clk;

    pmp_bound_stack #(.Depth(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .enter      (enter),
        .enter_prio (enter_prio),
        .exit       (exit),
        .sp         (sp),
        .ep         (ep),
`ifdef PMP_BOUND_FAULT_EN
        .fault      (fault),
`endif
        .cur_prio   (cur_prio),
        .level      (level),
        .full       (full),
        .empty      (empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] e_ep;
        logic [7:0]  e_prio;
        e_ep   = (q.size() == 0) ? 16'hFFFF : q[q.size()-1].ep;
        e_prio = (q.size() == 0) ? 8'h00 : q[q.size()-1].prio;
        chk({tag, ".ep"}, 32'(ep), 32'(e_ep));
        chk({tag, ".cur_prio"}, 32'(cur_prio), 32'(e_prio));
        chk({tag, ".level"}, 32'(level), 32'(q.size()));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == 8));
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
`ifdef PMP_BOUND_FAULT_EN
        chk({tag, ".fault"}, 32'(fault), 32'(exp_fault));
`endif
    endtask

    task automatic cycle(input string tag, input logic en, input logic ex,
                         input logic [15:0] s, input logic [7:0] p, input logic rst);
        frame_t f;
        f.ep = s;
        f.prio = p;
        enter = en; exit = ex; sp = s; enter_prio = p; reset = rst;
        exp_fault = 1'b0;
        if (rst) begin
            q.delete();
        end else if (en && ex && q.size() != 0) begin
            q[q.size()-1] = f;
        end else if (en) begin
            if (q.size() < 8) q.push_back(f);
            else exp_fault = 1'b1;
        end else if (ex) begin
            if (q.size() > 0) void'(q.pop_back());
            else exp_fault = 1'b1;
        end
        @(posedge clk);
        #1;
        enter = 1'b0; exit = 1'b0; reset = 1'b0;
        check_all(tag);
    endtask

    initial begin
        @(negedge clk);
        cycle("reset", 0, 0, 16'h0, 8'h0, 1);
        cycle("reset2", 0, 0, 16'h0, 8'h0, 1);

        cycle("enter1", 1, 0, 16'h0F00, 8'd3, 0);
        cycle("enter2", 1, 0, 16'h0E80, 8'd5, 0);
        chk("enter2.ep_const", 32'(ep), 32'h0E80);
        cycle("exit1", 0, 1, 16'h0, 8'd0, 0);
        chk("exit1.ep_const", 32'(ep), 32'h0F00);
        cycle("tailchain", 1, 1, 16'h0EF0, 8'd4, 0);
        chk("tailchain.ep_const", 32'(ep), 32'h0EF0);

        cycle("reset3", 0, 0, 16'h0, 8'h0, 1);
        for (int i = 0; i < 8; i++) begin
            cycle("fill", 1, 0, 16'(16'h1000 - 16 * i), 8'(i + 1), 0);
        end
        chk("fill.ep_const", 32'(ep), 32'h0F90);
        chk("fill.full_const", 32'(full), 32'h1);
        cycle("overflow", 1, 0, 16'h0123, 8'd9, 0);
        cycle("after_overflow", 0, 0, 16'h0, 8'd0, 0);
        cycle("full_tailchain", 1, 1, 16'h0A00, 8'd7, 0);

        cycle("reset4", 0, 0, 16'h0, 8'h0, 1);
        cycle("underflow", 0, 1, 16'h0, 8'd0, 0);
        cycle("after_underflow", 0, 0, 16'h0, 8'd0, 0);
        cycle("empty_tailchain", 1, 1, 16'h0B00, 8'd2, 0);
        cycle("drain", 0, 1, 16'h0, 8'd0, 0);

        for (int i = 0; i < 3; i++) cycle("lvl3", 1, 0, 16'(16'h2000 - i), 8'(i), 0);
        cycle("reset_enter", 1, 0, 16'h0C00, 8'd6, 1);
        chk("reset_enter.level_const", 32'(level), 32'h0);

        for (int i = 0; i < 400; i++) begin
            int r;
            logic en, ex, rs;
            r  = int'($urandom_range(0, 99));
            rs = (r == 0);
            en = (r < 55) || (r >= 85);
            ex = (r >= 40);
            cycle("rand", en, ex, 16'($urandom), 8'($urandom), rs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
